posit_accum_issue: RTL and testbench



---
 rtl/posit_defines.sv | 19 +
 rtl/posit_term_fifo.sv | 56 +++++
 rtl/posit_accum_issue.sv | 134 +++++++++++++
 tb/tb_posit_accum_issue.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_defines.sv
// Shared constants and types for the posit accumulator datapath.
//   ACC_OUT_STAGES     - output pipeline stages configured on positaccum_8
//   ACC_ISSUE_INTERVAL - accumulator feedback loop length in cycles
//   ACC_RESULT_DELAY   - cycles from issue until the accumulator result is updated
//   accum_term_t       - one buffered term: group-end flag plus 32-bit posit
package posit_defines;

    localparam int unsigned ACC_OUT_STAGES     = 7;
    // The loop is the output stages plus the fixed 9-stage adder core.
    localparam int unsigned ACC_ISSUE_INTERVAL = ACC_OUT_STAGES + 9;
    // The sum is readable once the term has travelled the whole loop.
    localparam int unsigned ACC_RESULT_DELAY   = ACC_ISSUE_INTERVAL;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } accum_term_t;

endpackage

// File: rtl/posit_term_fifo.sv
// Synchronous FIFO for accumulator terms, asynchronous active-high reset.
//   clk, rst       - clock, async reset (empties the FIFO)
//   push, wr_data  - write strobe and term; ignored when full
//   pop, rd_data   - read strobe and head-of-queue term (valid when count != 0)
//   count          - registered occupancy, 0..DEPTH
module posit_term_fifo
    import posit_defines::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  accum_term_t                  wr_data,
    input  logic                         pop,
    output accum_term_t                  rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    accum_term_t     mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count != CntW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/posit_accum_issue.sv
// Front-end scheduler for the posit accumulator. Buffers grouped terms and issues
// one per loop period so a whole group lands on one feedback lane, then captures,
// presents and clears the group sum.
//   clk, rst                        - clock, async active-high reset
//   in_data/in_last/in_valid/ready  - term input stream
//   acc_in1/acc_start/acc_clear     - accumulator drive (acc_clear feeds its reset)
//   acc_result/acc_inf/acc_zero     - accumulator result
//   sum_data/inf/zero/valid/ready   - completed group sum stream
module posit_accum_issue
    import posit_defines::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ISSUE_INTERVAL = ACC_ISSUE_INTERVAL,
    parameter int unsigned RESULT_DELAY   = ACC_RESULT_DELAY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] acc_in1,
    output logic        acc_start,
    output logic        acc_clear,
    input  logic [31:0] acc_result,
    input  logic        acc_inf,
    input  logic        acc_zero,
    output logic [31:0] sum_data,
    output logic        sum_inf,
    output logic        sum_zero,
    output logic        sum_valid,
    input  logic        sum_ready
);

    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned SlotW  = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam int unsigned DrainW = $clog2(RESULT_DELAY + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StOutput, StClear} issue_state_t;

    issue_state_t      state_q;
    logic [SlotW-1:0]  slot_q;
    logic [DrainW-1:0] drain_q;

    accum_term_t       fifo_in;
    accum_term_t       fifo_head;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign fifo_in.last = in_last;
    assign fifo_in.data = in_data;
    assign in_ready     = fifo_count < CntW'(DEPTH);
    assign push         = in_valid & in_ready;
    assign fifo_empty   = (fifo_count == '0);
    // Only slot 0 may issue; an empty FIFO there burns the whole interval.
    assign pop          = (state_q == StIssue) && (slot_q == '0) && !fifo_empty;
    assign acc_clear    = rst | (state_q == StClear);

    posit_term_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (fifo_in),
        .pop     (pop),
        .rd_data (fifo_head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            slot_q    <= '0;
            drain_q   <= '0;
            acc_in1   <= '0;
            acc_start <= 1'b0;
            sum_data  <= '0;
            sum_inf   <= 1'b0;
            sum_zero  <= 1'b1;
            sum_valid <= 1'b0;
        end else begin
            // Zero is added on every cycle without an issue.
            acc_in1 <= '0;
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q   <= StIssue;
                        slot_q    <= '0;
                        acc_start <= 1'b1;
                    end
                end
                StIssue: begin
                    if (slot_q == SlotW'(ISSUE_INTERVAL - 1)) slot_q <= '0;
                    else                                      slot_q <= slot_q + SlotW'(1);
                    if (pop) begin
                        acc_in1 <= fifo_head.data;
                        if (fifo_head.last) begin
                            drain_q <= DrainW'(RESULT_DELAY);
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == '0) begin
                        sum_data  <= acc_result;
                        sum_inf   <= acc_inf;
                        sum_zero  <= acc_zero;
                        sum_valid <= 1'b1;
                        acc_start <= 1'b0;
                        state_q   <= StOutput;
                    end else begin
                        drain_q <= drain_q - DrainW'(1);
                    end
                end
                StOutput: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_posit_accum_issue.sv
// Self-checking bench for posit_accum_issue with a behavioural accumulator model
// (fixed-latency adder over a small table of posit values, ES=2).
module tb_posit_accum_issue;

    localparam int LAT       = 16;  // accumulator: issue cycle to updated result
    localparam int GROUP_LAT = 17;  // last issue to sum_valid rising
    localparam int INTERVAL  = 16;
    localparam int BOUND     = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] acc_in1;
    logic        acc_start;
    logic        acc_clear;
    logic [31:0] acc_result = '0;
    logic        acc_inf = 1'b0;
    logic        acc_zero = 1'b1;
    logic [31:0] sum_data;
    logic        sum_inf;
    logic        sum_zero;
    logic        sum_valid;
    logic        sum_ready = 1'b1;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        inf;
    } exp_t;

    exp_t        exp_q[$];
    int          issue_q[$];
    int          tests_run = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_issue = 0;
    int          n_issues = 0;
    int          clear_pulses = 0;
    int          pipe[LAT];
    int          acc_sum = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_data = '0;

    posit_accum_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_in1    (acc_in1),
        .acc_start  (acc_start),
        .acc_clear  (acc_clear),
        .acc_result (acc_result),
        .acc_inf    (acc_inf),
        .acc_zero   (acc_zero),
        .sum_data   (sum_data),
        .sum_inf    (sum_inf),
        .sum_zero   (sum_zero),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready)
    );

    initial forever #5 clk = ~clk;

    function automatic int dec(input logic [31:0] p);
        case (p)
            32'h4000_0000: return 1;
            32'hC000_0000: return -1;
            default:       return 0;
        endcase
    endfunction

    function automatic logic [31:0] enc(input int s);
        case (s)
            0:       return 32'h0000_0000;
            1:       return 32'h4000_0000;
            2:       return 32'h4800_0000;
            3:       return 32'h4C00_0000;
            4:       return 32'h5000_0000;
            -1:      return 32'hC000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // One cycle: sample at the falling edge, score outputs, advance accumulator model.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (acc_in1 != 32'h0) begin
            issue_q.push_back(cyc);
            last_issue = cyc;
            n_issues++;
            tests_run++;
            if (acc_start !== 1'b1) begin
                failures++;
                $display("FAIL issue_start: acc_start=%b required 1 (cycle %0d)", acc_start, cyc);
            end
        end
        if (acc_clear === 1'b1 && !rst) clear_pulses++;
        if (sum_valid === 1'b1 && !prev_valid) begin
            tests_run++;
            if (cyc - last_issue != GROUP_LAT) begin
                failures++;
                $display("FAIL group_latency: got %0d required %0d", cyc - last_issue, GROUP_LAT);
            end
            tests_run++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sum: got %h with no group outstanding", sum_data);
            end else begin
                e = exp_q.pop_front();
                if ({sum_data, sum_zero, sum_inf} !== {e.data, e.zero, e.inf}) begin
                    failures++;
                    $display("FAIL sum: got data=%h zero=%b inf=%b required data=%h zero=%b inf=%b",
                             sum_data, sum_zero, sum_inf, e.data, e.zero, e.inf);
                end
            end
        end else if (sum_valid === 1'b1 && prev_valid) begin
            tests_run++;
            if (sum_data !== prev_data) begin
                failures++;
                $display("FAIL sum_hold: got %h required %h", sum_data, prev_data);
            end
        end
        prev_valid = (sum_valid === 1'b1);
        prev_data  = sum_data;
        if (acc_clear !== 1'b0) begin
            acc_sum = 0;
            for (int i = 0; i < LAT; i++) pipe[i] = 0;
        end else begin
            acc_sum += pipe[LAT-1];
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = acc_start ? dec(acc_in1) : 0;
        end
        acc_result = enc(acc_sum);
        acc_zero   = (acc_sum == 0);
        acc_inf    = 1'b0;
    endtask

    task automatic push_term(input logic [31:0] d, input logic l);
        int t = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < BOUND) begin
            step();
            t++;
        end
        tests_run++;
        if (t >= BOUND) begin
            failures++;
            $display("FAIL push_timeout: in_ready=%b required 1 within %0d cycles", in_ready, BOUND);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || sum_valid === 1'b1) && t < BOUND) begin
            step();
            t++;
        end
        tests_run++;
        if (t >= BOUND) begin
            failures++;
            $display("FAIL done_timeout: %0d sums outstanding, required 0", exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        tests_run += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        if (acc_in1 !== 32'h0 || acc_start !== 1'b0) begin
            failures++;
            $display("FAIL rst_acc: got in1=%h start=%b required 0/0", acc_in1, acc_start);
        end
        if (acc_clear !== 1'b1) begin failures++; $display("FAIL rst_acc_clear: got %b required 1", acc_clear); end
        if (sum_data !== 32'h0 || sum_inf !== 1'b0 || sum_zero !== 1'b1) begin
            failures++;
            $display("FAIL rst_sum: got %h/%b/%b required 0/0/1", sum_data, sum_inf, sum_zero);
        end
        if (sum_valid !== 1'b0) begin failures++; $display("FAIL rst_sum_valid: got %b required 0", sum_valid); end
        rst = 1'b0;
        step();
        tests_run++;
        if (acc_clear !== 1'b0) begin failures++; $display("FAIL post_rst_clear: got %b required 0", acc_clear); end
    endtask

    task automatic test_four_ones();
        issue_q.delete();
        clear_pulses = 0;
        sum_ready = 1'b1;
        exp_q.push_back('{32'h5000_0000, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) push_term(32'h4000_0000, i == 3);
        wait_done();
        tests_run++;
        if (issue_q.size() != 4) begin
            failures++;
            $display("FAIL four_issue_count: got %0d required 4", issue_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                tests_run++;
                if (issue_q[i] - issue_q[i-1] != INTERVAL) begin
                    failures++;
                    $display("FAIL issue_spacing: got %0d required %0d", issue_q[i] - issue_q[i-1], INTERVAL);
                end
            end
        end
        tests_run++;
        if (clear_pulses != 1) begin
            failures++;
            $display("FAIL clear_pulse: got %0d cycles required 1", clear_pulses);
        end
    endtask

    task automatic test_single_neg();
        exp_q.push_back('{32'hC000_0000, 1'b0, 1'b0});
        push_term(32'hC000_0000, 1'b1);
        wait_done();
    endtask

    task automatic test_fifo_fill();
        int   t = 0;
        logic seen_clear = 1'b0;
        sum_ready = 1'b0;
        exp_q.push_back('{32'h4000_0000, 1'b0, 1'b0});
        push_term(32'h4000_0000, 1'b1);
        while (sum_valid !== 1'b1 && t < BOUND) begin step(); t++; end
        tests_run++;
        if (t >= BOUND) begin failures++; $display("FAIL fill_output_timeout: sum_valid=%b required 1", sum_valid); end
        // 16 alternating +1/-1 terms, then a final +1: group sum is +1.
        exp_q.push_back('{32'h4000_0000, 1'b0, 1'b0});
        for (int i = 0; i < 16; i++) push_term((i % 2 == 0) ? 32'h4000_0000 : 32'hC000_0000, 1'b0);
        tests_run++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_full: in_ready=%b required 0", in_ready); end
        in_data  = 32'h4000_0000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (10) begin
            step();
            tests_run++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_stall: in_ready=%b required 0", in_ready); end
        end
        sum_ready = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            step();
            if (acc_clear === 1'b1) seen_clear = 1'b1;
            t++;
        end
        tests_run += 2;
        if (!seen_clear) begin failures++; $display("FAIL fill_accept_early: clear seen=%b required 1", seen_clear); end
        if (acc_in1 !== 32'h4000_0000) begin
            failures++;
            $display("FAIL fill_first_pop: acc_in1=%h required 40000000 when in_ready rises", acc_in1);
        end
        step();
        in_valid = 1'b0;
        wait_done();
    endtask

    task automatic test_gap();
        issue_q.delete();
        exp_q.push_back('{32'h4800_0000, 1'b0, 1'b0});
        push_term(32'h4000_0000, 1'b0);
        repeat (40) step();
        push_term(32'h4000_0000, 1'b1);
        wait_done();
        tests_run++;
        if (issue_q.size() != 2) begin
            failures++;
            $display("FAIL gap_issue_count: got %0d required 2", issue_q.size());
        end else begin
            tests_run++;
            if ((issue_q[1] - issue_q[0]) % INTERVAL != 0 || issue_q[1] - issue_q[0] <= INTERVAL) begin
                failures++;
                $display("FAIL gap_alignment: gap %0d required multiple of %0d above %0d",
                         issue_q[1] - issue_q[0], INTERVAL, INTERVAL);
            end
        end
    endtask

    task automatic test_cancel();
        exp_q.push_back('{32'h0000_0000, 1'b1, 1'b0});
        push_term(32'h4000_0000, 1'b0);
        push_term(32'hC000_0000, 1'b1);
        wait_done();
    endtask

    task automatic test_reset_drain();
        int t = 0;
        int n0 = n_issues;
        int bad = 0;
        push_term(32'h4000_0000, 1'b1);
        while (n_issues == n0 && t < BOUND) begin step(); t++; end
        tests_run++;
        if (t >= BOUND) begin failures++; $display("FAIL drain_issue_timeout: issues=%0d required %0d", n_issues, n0 + 1); end
        repeat (5) step();
        rst = 1'b1;
        repeat (3) begin
            step();
            tests_run++;
            if (acc_clear !== 1'b1 || sum_valid !== 1'b0) begin
                failures++;
                $display("FAIL drain_rst: clear=%b valid=%b required 1/0", acc_clear, sum_valid);
            end
        end
        rst = 1'b0;
        repeat (30) begin
            step();
            if (sum_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin failures++; $display("FAIL drain_discard: sum_valid high %0d cycles required 0", bad); end
        exp_q.push_back('{32'h4800_0000, 1'b0, 1'b0});
        push_term(32'h4000_0000, 1'b0);
        push_term(32'h4000_0000, 1'b1);
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = 0;
        test_reset();
        test_four_ones();
        test_single_neg();
        test_fifo_fill();
        test_gap();
        test_cancel();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
